// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared RV32I pipeline types: forwarding-mux select encoding and the
// hazard controller state encoding.
package rv32i_types;

    localparam int unsigned REG_AW = 5;

    // EX operand mux select; 2'b11 is never produced.
    typedef enum logic [1:0] {
        NONE = 2'b00,
        WB   = 2'b01,
        MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        LU_STALL = 2'b01,
        MEM_WAIT = 2'b10
    } hzd_state_t;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): ID-stage operand info, EX/MEM events in, stall/flush/forward out.
interface ex_hazard_ctrl_if;
    import rv32i_types::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_is_load;
    logic              ex_br_taken;
    logic              mem_dreq;
    logic              mem_dresp;
    fwd_sel_t          ex_fwd_sel1;
    fwd_sel_t          ex_fwd_sel2;
    logic              stall_pc;
    logic              stall_ifid;
    logic              bubble_idex;
    logic              flush_ifid;
    logic              freeze;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_is_load, ex_br_taken, mem_dreq, mem_dresp,
        input  ex_fwd_sel1, ex_fwd_sel2, stall_pc, stall_ifid, bubble_idex,
               flush_ifid, freeze
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_regwrite, id_is_load, ex_br_taken, mem_dreq, mem_dresp,
        output ex_fwd_sel1, ex_fwd_sel2, stall_pc, stall_ifid, bubble_idex,
               flush_ifid, freeze
    );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_select.sv
// Forwarding select for one ID source operand. The EX slot holds the
// instruction that will be in MEM next cycle, so it is the younger producer
// and wins over the MEM slot (which will be in WB).
module fwd_select
    import rv32i_types::*;
(
    input  logic              use_i,
    input  logic [REG_AW-1:0] rs_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_wr_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              mem_wr_i,
    output fwd_sel_t          sel_o
);

    // x0 and unused operands never forward.
    always_comb begin
        sel_o = NONE;
        if (use_i && (rs_i != '0)) begin
            if (ex_wr_i && (rs_i == ex_rd_i)) begin
                sel_o = MEM;
            end else if (mem_wr_i && (rs_i == mem_rd_i)) begin
                sel_o = WB;
            end
        end
    end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX hazard controller: tracks the destinations of the instructions in the
// EX and MEM slots, registers forwarding selects for the instruction moving
// into EX, and arbitrates memory freeze > branch flush > load-use stall.
module ex_hazard_ctrl
    import rv32i_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    ex_hazard_ctrl_if.slave hz
);

    hzd_state_t        state_q, state_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_wr_q, ex_wr_d;
    logic              ex_ld_q, ex_ld_d;
    logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    fwd_sel_t          sel1_q, sel1_d;
    fwd_sel_t          sel2_q, sel2_d;
    fwd_sel_t          sel1_c, sel2_c;
    logic              mem_hold;
    logic              rs_hit;
    logic              br_flush;
    logic              lu_hazard;

    fwd_select u_fwd1 (
        .use_i    (hz.id_use_rs1),
        .rs_i     (hz.id_rs1),
        .ex_rd_i  (ex_rd_q),
        .ex_wr_i  (ex_wr_q),
        .mem_rd_i (mem_rd_q),
        .mem_wr_i (mem_wr_q),
        .sel_o    (sel1_c)
    );

    fwd_select u_fwd2 (
        .use_i    (hz.id_use_rs2),
        .rs_i     (hz.id_rs2),
        .ex_rd_i  (ex_rd_q),
        .ex_wr_i  (ex_wr_q),
        .mem_rd_i (mem_rd_q),
        .mem_wr_i (mem_wr_q),
        .sel_o    (sel2_c)
    );

    // Hazard conditions, already ranked: a pending data access masks the
    // branch, and a taken branch squashes the ID instruction so it cannot stall.
    always_comb begin
        mem_hold  = !hz.mem_dresp && (hz.mem_dreq || (state_q == MEM_WAIT));
        rs_hit    = (hz.id_use_rs1 && (hz.id_rs1 == ex_rd_q)) ||
                    (hz.id_use_rs2 && (hz.id_rs2 == ex_rd_q));
        br_flush  = !mem_hold && hz.ex_br_taken;
        lu_hazard = !mem_hold && !hz.ex_br_taken && hz.id_valid &&
                    ex_ld_q && ex_wr_q && (ex_rd_q != '0) && rs_hit;
    end

    // Pipeline controls are gated by rst_n so they drop the moment reset
    // asserts, even while the memory request inputs are still active.
    assign hz.freeze      = rst_n && mem_hold;
    assign hz.stall_pc    = rst_n && (mem_hold || lu_hazard);
    assign hz.stall_ifid  = rst_n && (mem_hold || lu_hazard);
    assign hz.bubble_idex = rst_n && (br_flush || lu_hazard);
    assign hz.flush_ifid  = rst_n && br_flush;
    assign hz.ex_fwd_sel1 = sel1_q;
    assign hz.ex_fwd_sel2 = sel2_q;

    // Next state plus the ID->EX->MEM shift of the tracking slots; everything
    // holds while frozen, and a bubble enters EX as an empty, non-forwarding slot.
    always_comb begin
        // NOTE: each target gets a default first so no path leaves it unassigned (no latches).
        state_d  = RUN;
        ex_rd_d  = ex_rd_q;
        ex_wr_d  = ex_wr_q;
        ex_ld_d  = ex_ld_q;
        mem_rd_d = mem_rd_q;
        mem_wr_d = mem_wr_q;
        sel1_d   = sel1_q;
        sel2_d   = sel2_q;

        if (mem_hold) begin
            state_d = MEM_WAIT;
        end else if (lu_hazard) begin
            state_d = LU_STALL;
        end

        if (!mem_hold) begin
            mem_rd_d = ex_rd_q;
            mem_wr_d = ex_wr_q;
            if (br_flush || lu_hazard) begin
                ex_rd_d = '0;
                ex_wr_d = 1'b0;
                ex_ld_d = 1'b0;
                sel1_d  = NONE;
                sel2_d  = NONE;
            end else begin
                ex_rd_d = hz.id_rd;
                ex_wr_d = hz.id_valid && hz.id_regwrite;
                ex_ld_d = hz.id_valid && hz.id_is_load;
                sel1_d  = sel1_c;
                sel2_d  = sel2_c;
            end
        end
    end

    // State, tracking and select registers; reset empties the tracking slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            ex_rd_q  <= '0;
            ex_wr_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_wr_q <= 1'b0;
            sel1_q   <= NONE;
            sel2_q   <= NONE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q  <= state_d;
            ex_rd_q  <= ex_rd_d;
            ex_wr_q  <= ex_wr_d;
            ex_ld_q  <= ex_ld_d;
            mem_rd_q <= mem_rd_d;
            mem_wr_q <= mem_wr_d;
            sel1_q   <= sel1_d;
            sel2_q   <= sel2_d;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: a table of single-cycle vectors for
// forwarding, load-use and branch flush, then hand-written sequences for
// the memory wait and reset-during-wait cases.
module tb_ex_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    ex_hazard_ctrl_if hz ();

    ex_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic       dreq;
        logic       dresp;
        logic [1:0] sel1;
        logic [1:0] sel2;
        logic       spc;
        logic       sif;
        logic       bub;
        logic       fl;
        logic       frz;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input int valid, input int rs1, input int u1,
                                input int rs2, input int u2, input int rd,
                                input int wr, input int ld, input int br,
                                input int dreq, input int dresp,
                                input int s1, input int s2, input int spc,
                                input int sif, input int bub, input int fl,
                                input int frz);
        vec_t v;
        v.valid = 1'(valid); v.rs1 = 5'(rs1); v.u1 = 1'(u1);
        v.rs2 = 5'(rs2);     v.u2 = 1'(u2);   v.rd = 5'(rd);
        v.wr = 1'(wr);       v.ld = 1'(ld);   v.br = 1'(br);
        v.dreq = 1'(dreq);   v.dresp = 1'(dresp);
        v.sel1 = 2'(s1);     v.sel2 = 2'(s2);
        v.spc = 1'(spc);     v.sif = 1'(sif); v.bub = 1'(bub);
        v.fl = 1'(fl);       v.frz = 1'(frz);
        return v;
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int s1, input int s2,
                              input int spc, input int sif, input int bub,
                              input int fl, input int frz);
        check({tag, ".sel1"},        hz.ex_fwd_sel1,          2'(s1));
        check({tag, ".sel2"},        hz.ex_fwd_sel2,          2'(s2));
        check({tag, ".stall_pc"},    {1'b0, hz.stall_pc},     2'(spc));
        check({tag, ".stall_ifid"},  {1'b0, hz.stall_ifid},   2'(sif));
        check({tag, ".bubble_idex"}, {1'b0, hz.bubble_idex},  2'(bub));
        check({tag, ".flush_ifid"},  {1'b0, hz.flush_ifid},   2'(fl));
        check({tag, ".freeze"},      {1'b0, hz.freeze},       2'(frz));
    endtask

    task automatic drive_id(input int valid, input int rs1, input int u1,
                            input int rs2, input int u2, input int rd,
                            input int wr, input int ld);
        hz.id_valid    = 1'(valid);
        hz.id_rs1      = 5'(rs1);
        hz.id_use_rs1  = 1'(u1);
        hz.id_rs2      = 5'(rs2);
        hz.id_use_rs2  = 1'(u2);
        hz.id_rd       = 5'(rd);
        hz.id_regwrite = 1'(wr);
        hz.id_is_load  = 1'(ld);
    endtask

    task automatic drive_ctl(input int br, input int dreq, input int dresp);
        hz.ex_br_taken = 1'(br);
        hz.mem_dreq    = 1'(dreq);
        hz.mem_dresp   = 1'(dresp);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //       v rs1 u1 rs2 u2 rd wr ld br dq dr | s1 s2 spc sif bub fl frz
        vecs[0]  = mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 5, 1, 3, 1, 6, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 6, 1, 5, 1, 5, 1, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 5, 0, 5, 1, 8, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 5, 1, 0, 1, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0, 0);
        vecs[6]  = mk(1, 0, 1, 8, 0, 7, 1, 1, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0);
        vecs[7]  = mk(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0, 0);
        vecs[8]  = mk(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 9, 1, 0, 0, 10, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(1, 10, 1, 0, 0, 11, 1, 0, 1, 0, 0, 2, 0, 0, 0, 1, 1, 0);
        vecs[11] = mk(1, 10, 1, 0, 0, 11, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);

        // Reset with a request pending: controls must stay low.
        rst_n = 1'b0;
        drive_id(1, 5, 1, 5, 1, 5, 1, 1);
        drive_ctl(1, 1, 0);
        #3;
        check_outs("reset", 0, 0, 0, 0, 0, 0, 0);
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        drive_ctl(0, 0, 0);
        #19 rst_n = 1'b1;

        // Table: drive just after a rising edge, compare at the falling edge.
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            drive_id(vecs[i].valid, vecs[i].rs1, vecs[i].u1, vecs[i].rs2,
                     vecs[i].u2, vecs[i].rd, vecs[i].wr, vecs[i].ld);
            drive_ctl(vecs[i].br, vecs[i].dreq, vecs[i].dresp);
            @(negedge clk);
            check_outs($sformatf("v%0d", i), vecs[i].sel1, vecs[i].sel2,
                       vecs[i].spc, vecs[i].sif, vecs[i].bub, vecs[i].fl,
                       vecs[i].frz);
        end

        // Setup: x11 sits in the MEM slot, so rs1=x11 registers WB.
        @(posedge clk); #1;
        drive_id(1, 11, 1, 0, 0, 12, 1, 0);
        drive_ctl(0, 0, 0);
        @(negedge clk);
        check_outs("setup", 0, 0, 0, 0, 0, 0, 0);

        // Data access pending for three cycles; a branch in the second cycle
        // must not flush. Selects hold at WB/NONE throughout.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            drive_id(1, 12, 1, 12, 1, 13, 1, 1);
            drive_ctl((c == 1) ? 1 : 0, 1, 0);
            @(negedge clk);
            check_outs($sformatf("wait%0d", c), 1, 0, 1, 1, 0, 0, 1);
        end

        // Response arrives: freeze drops in the same cycle.
        @(posedge clk); #1;
        drive_ctl(0, 1, 1);
        @(negedge clk);
        check_outs("resp", 1, 0, 0, 0, 0, 0, 0);

        // The held ID instruction now advances against x12 in EX.
        @(posedge clk); #1;
        drive_id(1, 0, 0, 0, 0, 14, 1, 1);
        drive_ctl(0, 0, 0);
        @(negedge clk);
        check_outs("post_resp", 2, 2, 0, 0, 0, 0, 0);

        // lw x14 in EX with a load-use in ID, but a data access stalls too:
        // freeze wins, so no bubble.
        @(posedge clk); #1;
        drive_id(1, 14, 1, 0, 0, 15, 1, 0);
        drive_ctl(0, 1, 0);
        @(negedge clk);
        check_outs("frz_over_lu", 0, 0, 1, 1, 0, 0, 1);

        // Now in MEM_WAIT; reset mid-cycle must drop everything at once.
        @(posedge clk); #1;
        check({"in_wait", ".freeze"}, {1'b0, hz.freeze}, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check_outs("rst_in_wait", 0, 0, 0, 0, 0, 0, 0);
        drive_ctl(0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        // Stale state would still freeze (MEM_WAIT) or stall (lw x14 in EX).
        check_outs("after_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_outs("after_rst_edge", 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 SHALL have a single clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be, clock and reset first (name  direction  width  meaning):
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  ID source registers
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1/rs2
- id_rd  in  5  ID destination register
- id_regwrite  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_br_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_dreq  in  1  MEM stage issuing a data access
- mem_dresp  in  1  data memory completes the access
- ex_fwd_sel1, ex_fwd_sel2  out  2 each  EX forwarding mux selects: 00 none, 01 WB, 10 MEM, 11 unused
- stall_pc, stall_ifid  out  1 each  hold PC / IF-ID register
- bubble_idex  out  1  load NOP into ID/EX
- flush_ifid  out  1  load NOP into IF/ID
- freeze  out  1  hold every pipeline register

Function
REQ-003 SHALL keep shadow tracking registers ex_rd/ex_wr/ex_ld and mem_rd/mem_wr, shifted ID->EX->MEM on each advancing edge (freeze=0); a bubble or flush loads rd=0, wr=0, ld=0 into the EX slot.
REQ-004 SHALL compute each forwarding select from ID sources against EX-slot (becomes MEM) and MEM-slot (becomes WB) entries and register it into ex_fwd_selN on the advancing edge, so the selects are valid the cycle the instruction is in EX.
REQ-005 Select rule per source: 10 if use && rs==ex_rd && ex_wr && rs!=0; else 01 if use && rs==mem_rd && mem_wr && rs!=0; else 00; MEM SHALL win over WB when both match.
REQ-006 Register x0 SHALL never be forwarded; an unused source SHALL yield 00.
REQ-007 FSM states RUN, LU_STALL, MEM_WAIT; reset state RUN.
REQ-008 RUN->LU_STALL when id_valid && ex_ld && ex_wr && ex_rd!=0 && an ID source in use matches ex_rd, and ex_br_taken=0; outputs that cycle: stall_pc=1, stall_ifid=1, bubble_idex=1.
REQ-009 LU_STALL SHALL last exactly one cycle, then return to RUN; the stalled instruction re-evaluates and receives select 01 or 10.
REQ-010 Any state->MEM_WAIT when mem_dreq=1 and mem_dresp=0; in MEM_WAIT freeze=1, stall_pc=1, stall_ifid=1, no bubble/flush, tracking and select registers hold.
REQ-011 MEM_WAIT->RUN in the cycle mem_dresp=1 (freeze deasserts combinationally that cycle); a same-cycle dreq with dresp SHALL cause no freeze.
REQ-012 ex_br_taken=1 (not frozen) SHALL assert flush_ifid=1 and bubble_idex=1 for one cycle and suppress any load-use stall that cycle.
REQ-013 Priority SHALL be freeze > branch flush > load-use stall.
REQ-014 Latency: selects are registered (1 cycle from ID), stall/flush/freeze outputs are combinational from state and inputs.

Reset
REQ-015 On rst_n=0 SHALL immediately force state RUN, all tracking registers 0, ex_fwd_sel1/2=00; stall_pc, stall_ifid, bubble_idex, flush_ifid and freeze SHALL be 0.
REQ-016 Reset asserted mid-stall or mid-MEM_WAIT SHALL abandon it; the first edge after release SHALL behave as RUN with empty tracking.

Structure
REQ-017 fwd_sel_t (2-bit enum NONE/WB/MEM) and hzd_state_t SHALL live in the shared rv32i_types package.
REQ-018 Per-source select logic SHALL be one sub-module, fwd_select, instantiated twice.

Verification
REQ-019 Bench SHALL cover:
- add x5 in EX (wr=1), ID reads rs1=x5 -> next cycle ex_fwd_sel1=10, no stall.
- x5 in MEM slot and EX slot both writing, ID rs2=x5 -> ex_fwd_sel2=10; with only the MEM slot matching -> 01.
- lw x7 in EX, ID rs1=x7 -> one cycle stall_pc=stall_ifid=bubble_idex=1, next cycle ex_fwd_sel1=01, no second stall.
- ID rs1=x0 with EX rd=x0, wr=1 -> ex_fwd_sel1=00, no stall.
- mem_dreq=1, dresp low 3 cycles -> freeze=1 for exactly 3 cycles, selects unchanged; plus ex_br_taken=1 coincident with load-use -> flush_ifid=bubble_idex=1, stall_pc=0.
- rst_n low during MEM_WAIT -> freeze=0 immediately, selects=00.
